// File: rtl/pckgen_pkg.sv
// pckgen_pkg: shared types, widths and mode-table helpers for the fractional pixel clock-enable generator.
package pckgen_pkg;
   localparam int MODE_W = 4;
   localparam int MAX_BITS = 256;
   typedef enum logic [0:0] {SETTLE = 1'b0, RUN = 1'b1} state_e;
   function automatic int settle_w(input int settle_cyc);
      return $clog2(settle_cyc + 1);
   endfunction
   // Pulls field idx of width w out of a packed per-mode table (mode0 in the LSBs).
   function automatic int unsigned mode_field(input logic [MAX_BITS-1:0] v, input int unsigned idx, input int unsigned w);
      return 32'((v >> (idx * w)) & ((MAX_BITS'(1) << w) - MAX_BITS'(1)));
   endfunction
endpackage

// File: rtl/pckgen_frac_if.sv
// pckgen_frac_if: mode request/status and pixel-enable bundle between a controller and the generator.
interface pckgen_frac_if;
   import pckgen_pkg::*;
   logic [MODE_W-1:0] MODE_SEL;
   logic [MODE_W-1:0] CUR_MODE;
   logic              MODE_REQ;
   logic              MODE_RDY;
   logic              MODE_ERR;
   logic              LOCKED;
   logic              PCE;
   modport master (output MODE_SEL, MODE_REQ, input MODE_RDY, MODE_ERR, CUR_MODE, LOCKED, PCE);
   modport slave  (input MODE_SEL, MODE_REQ, output MODE_RDY, MODE_ERR, CUR_MODE, LOCKED, PCE);
endinterface

// File: rtl/frac_cegen.sv
// frac_cegen: rational accumulator emitting a registered one-cycle enable at average rate num/den.
module frac_cegen #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] num_i,
   input  logic [CNT_W-1:0] den_i,
   output logic             pce_o
);
   logic [CNT_W-1:0] acc_q, acc_d;
   logic [CNT_W:0]   sum;
   logic             pce_d;
   // num <= den keeps acc < den, so the extra sum bit never overflows.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, num_i};
      pce_d = !clr_i && en_i && (sum >= {1'b0, den_i});
      acc_d = clr_i ? '0 : !en_i ? acc_q : pce_d ? CNT_W'(sum - {1'b0, den_i}) : sum[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc_q <= '0;
         pce_o <= 1'b0;
      end else begin
         acc_q <= acc_d;
         pce_o <= pce_d;
      end
endmodule

// File: rtl/pckgen_frac.sv
// pckgen_frac: multi-mode pixel clock-enable generator with request arbitration, settle window and LOCKED.
module pckgen_frac
   import pckgen_pkg::*;
#(
   parameter int NUM_MODES = 4,
   parameter int CNT_W = 8,
   parameter logic [NUM_MODES*CNT_W-1:0] MODE_NUM = {8'd1, 8'd13, 8'd8, 8'd1},
   parameter logic [NUM_MODES*CNT_W-1:0] MODE_DEN = {8'd1, 8'd25, 8'd25, 8'd5},
   parameter int DEFAULT_MODE = 0,
   parameter int SETTLE_CYC = 16
) (
   input logic          SYSCLK,
   input logic          RST_N,
   pckgen_frac_if.slave bus
);
   localparam int CW = settle_w(SETTLE_CYC);
   localparam logic [MAX_BITS-1:0] NUM_V = MAX_BITS'(MODE_NUM);
   localparam logic [MAX_BITS-1:0] DEN_V = MAX_BITS'(MODE_DEN);
   localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYC - 1);
   localparam logic [MODE_W-1:0] DEF = MODE_W'(DEFAULT_MODE);
   localparam logic [MODE_W:0] NM = (MODE_W + 1)'(NUM_MODES);
   logic [CNT_W-1:0] num_tbl [1<<MODE_W];
   logic [CNT_W-1:0] den_tbl [1<<MODE_W];
   // Tables are padded to the full index range so any CUR_MODE value selects a defined entry.
   for (genvar m = 0; m < (1 << MODE_W); m++) begin : g_tbl
      if (m < NUM_MODES) begin : g_mode
         localparam int unsigned N = mode_field(NUM_V, m, CNT_W);
         localparam int unsigned D = mode_field(DEN_V, m, CNT_W);
         if (N < 1 || N > D) begin : g_bad
            $error("pckgen_frac: mode %0d needs 1 <= NUM <= DEN", m);
         end
         assign num_tbl[m] = CNT_W'(N);
         assign den_tbl[m] = CNT_W'(D);
      end else begin : g_pad
         assign num_tbl[m] = '0;
         assign den_tbl[m] = '1;
      end
   end
   if (DEFAULT_MODE >= NUM_MODES || SETTLE_CYC < 1 || NUM_MODES > 16) begin : g_bad_cfg
      $error("pckgen_frac: invalid DEFAULT_MODE, SETTLE_CYC or NUM_MODES");
   end
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic              rdy_q, err_q;
   logic              req_ok, req_bad;
   always_comb begin
      req_ok  = bus.MODE_REQ && (state_q == RUN) && ({1'b0, bus.MODE_SEL} < NM);
      req_bad = bus.MODE_REQ && !req_ok;
      state_d = req_ok ? SETTLE : (state_q == SETTLE && cnt_q == '0) ? RUN : state_q;
      cnt_d   = req_ok ? RELOAD : (state_q == SETTLE && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      mode_d  = req_ok ? bus.MODE_SEL : mode_q;
   end
   always_ff @(posedge SYSCLK or negedge RST_N)
      if (!RST_N) begin
         state_q <= SETTLE;
         cnt_q   <= RELOAD;
         mode_q  <= DEF;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         rdy_q   <= state_d == RUN;
         err_q   <= req_bad;
      end
   // An accepted request clears the accumulator, so it also suppresses a PCE due that cycle.
   frac_cegen #(.CNT_W(CNT_W)) u_cegen (
      .clk   (SYSCLK),
      .rst_n (RST_N),
      .clr_i (state_q != RUN || req_ok),
      .en_i  (state_q == RUN),
      .num_i (num_tbl[mode_q]),
      .den_i (den_tbl[mode_q]),
      .pce_o (bus.PCE)
   );
   assign bus.CUR_MODE = mode_q;
   assign bus.LOCKED   = rdy_q;
   assign bus.MODE_RDY = rdy_q;
   assign bus.MODE_ERR = err_q;
endmodule

// File: tb/tb_pckgen_frac.sv
// tb_pckgen_frac: scoreboard bench; a rational-rate reference model predicts every cycle's outputs.
module tb_pckgen_frac;
   typedef struct packed {
      logic       pce;
      logic       locked;
      logic       rdy;
      logic       err;
      logic [3:0] mode;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   pckgen_frac_if bus();
   pckgen_frac dut (.SYSCLK(clk), .RST_N(rst_n), .bus(bus));
   always #4 clk = ~clk;
   exp_t q[$];
   int n_tests = 0, n_fail = 0, pce_cnt = 0;
   int num_t[4] = '{1, 8, 13, 1};
   int den_t[4] = '{5, 25, 25, 1};
   int m_mode, m_left, m_k;
   bit m_run;
   function automatic exp_t dut_out();
      return {bus.PCE, bus.LOCKED, bus.MODE_RDY, bus.MODE_ERR, bus.CUR_MODE};
   endfunction
   task automatic check(input string name, input exp_t got, input exp_t want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @%0t got pce=%b locked=%b rdy=%b err=%b mode=%0d want pce=%b locked=%b rdy=%b err=%b mode=%0d",
                  name, $time, got.pce, got.locked, got.rdy, got.err, got.mode,
                  want.pce, want.locked, want.rdy, want.err, want.mode);
      end
   endtask
   task automatic check_int(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask
   // Model: settle lasts 16 edges; in RUN the k-th cycle pulses when floor(k*N/D) steps up.
   task automatic model_reset();
      m_mode = 0; m_left = 16; m_k = 0; m_run = 0;
   endtask
   task automatic step(input bit req, input int sel);
      exp_t e;
      bit acc;
      @(negedge clk);
      bus.MODE_REQ = req;
      bus.MODE_SEL = 4'(sel);
      acc = req && m_run && sel < 4;
      if (acc) begin
         m_mode = sel; m_run = 0; m_left = 16; m_k = 0; e.pce = 1'b0;
      end else if (!m_run) begin
         m_left--; m_run = (m_left == 0); e.pce = 1'b0;
      end else begin
         m_k++;
         e.pce = ((m_k * num_t[m_mode]) / den_t[m_mode] - ((m_k - 1) * num_t[m_mode]) / den_t[m_mode]) != 0;
      end
      e.locked = m_run;
      e.rdy    = m_run;
      e.err    = req && !acc;
      e.mode   = 4'(m_mode);
      q.push_back(e);
   endtask
   task automatic sync();
      @(posedge clk);
      #2;
   endtask
   task automatic wait_lock();
      while (!m_run) step(0, 0);
   endtask
   task automatic settle_to(input int sel);
      wait_lock();
      step(1, sel);
      wait_lock();
   endtask
   task automatic window(input string name, input int n, input int want);
      int c0;
      sync();
      c0 = pce_cnt;
      repeat (n) step(0, 0);
      sync();
      check_int(name, pce_cnt - c0, want);
   endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            check("cycle", dut_out(), e);
            if (bus.PCE) pce_cnt++;
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end
   initial begin
      bus.MODE_REQ = 1'b0;
      bus.MODE_SEL = 4'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_values", dut_out(), '0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_lock();
      window("mode0_pulses", 1000, 200);
      settle_to(1);
      window("mode1_pulses", 1000, 320);
      settle_to(3);
      window("mode3_pulses", 100, 100);
      settle_to(2);
      window("mode2_pulses", 1000, 520);
      step(1, 7);
      repeat (30) step(0, 0);
      step(1, 0);
      repeat (5) step(0, 0);
      step(1, 1);
      wait_lock();
      repeat (3) step(1, 3);
      wait_lock();
      settle_to(0);
      repeat (4) step(0, 0);
      step(1, 0);
      wait_lock();
      repeat (3000) step($urandom_range(0, 39) == 0, int'($urandom_range(0, 7)));
      settle_to(2);
      repeat (7) step(0, 0);
      sync();
      #1 rst_n = 1'b0;
      #1 check("async_reset", dut_out(), '0);
      @(posedge clk);
      #1 check("reset_hold", dut_out(), '0);
      #1 rst_n = 1'b1;
      model_reset();
      wait_lock();
      repeat (20) step(0, 0);
      sync();
      check_int("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
